// File: rtl/window_buffer_3x3_pkg.sv
// Shared constants, types and a counter helper for the 3x3 window generator.
// The helper decides when a column/row counter is on its last value.
package window_buffer_3x3_pkg;

  localparam int KSZ     = 3;
  localparam int WIN_N   = 9;
  localparam int WIN_MID = 4;
  localparam int IDX_W   = 11;

  // Element positions, row-major, element 0 is the oldest pixel.
  localparam int E_TL = 0;
  localparam int E_TC = 1;
  localparam int E_TR = 2;
  localparam int E_ML = 3;
  localparam int E_MC = 4;
  localparam int E_MR = 5;
  localparam int E_BL = 6;
  localparam int E_BC = 7;
  localparam int E_BR = 8;

  typedef logic [IDX_W-1:0] idx_t;

  // A zero limit is treated as "always last" so the counter never runs away.
  function automatic logic is_last(input idx_t cur, input idx_t lim);
    logic [IDX_W:0] cur_p1;
    cur_p1 = {1'b0, cur} + {{IDX_W{1'b0}}, 1'b1};
    return (cur_p1 >= {1'b0, lim});
  endfunction

endpackage

// File: rtl/window_buffer_3x3_if.sv
// Pixel-stream and window-output bundle between a pixel source and the
// window generator. The source drives the master side.
interface window_buffer_3x3_if
  import window_buffer_3x3_pkg::*;
#(
  parameter int DW = 8
);

  logic [IDX_W-1:0]    IH;
  logic [IDX_W-1:0]    IW;
  logic                din_valid;
  logic [DW-1:0]       din;
  logic [WIN_N*DW-1:0] window_data_all;
  logic [DW-1:0]       window_mid;
  logic                dout_valid;

  modport master (
    output IH,
    output IW,
    output din_valid,
    output din,
    input  window_data_all,
    input  window_mid,
    input  dout_valid
  );

  modport slave (
    input  IH,
    input  IW,
    input  din_valid,
    input  din,
    output window_data_all,
    output window_mid,
    output dout_valid
  );

endinterface

// File: rtl/window_buffer_3x3_line_ram.sv
// One line store: simple dual-port RAM with a registered read port.
// A read and write to the same address in one cycle returns the old word.
module window_line_ram #(
  parameter int DW    = 8,
  parameter int MAX_W = 2048,
  parameter int AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [MAX_W];

  // Storage write and registered read; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/window_buffer_3x3.sv
// Streaming 3x3 neighbourhood generator: two line stores feed a 3x3 shift
// array, and a registered window is emitted for every interior pixel.
module window_buffer_3x3
  import window_buffer_3x3_pkg::*;
#(
  parameter int DW    = 8,
  parameter int MAX_W = 2048
) (
  input logic                clk,
  input logic                rst,
  window_buffer_3x3_if.slave bus
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  idx_t col_r;
  idx_t row_r;
  idx_t iw_r;
  idx_t ih_r;

  idx_t iw_s;
  idx_t ih_s;
  idx_t col_nxt_s;
  idx_t row_nxt_s;
  idx_t rd_addr_s;
  logic frame_start_s;
  logic col_last_s;
  logic row_last_s;
  logic accept_s;
  logic emit_s;

  logic [DW-1:0] l0_rd_s;
  logic [DW-1:0] l1_rd_s;

  logic [WIN_N-1:0][DW-1:0] win_r;
  logic [WIN_N-1:0][DW-1:0] win_nxt_s;
  logic [WIN_N-1:0][DW-1:0] out_win_r;
  logic [DW-1:0]            out_mid_r;
  logic                     out_valid_r;

  // Frame geometry is taken live on the first pixel, latched otherwise.
  always_comb begin
    frame_start_s = (col_r == '0) && (row_r == '0);
    if (frame_start_s) begin
      iw_s = bus.IW;
      ih_s = bus.IH;
    end else begin
      iw_s = iw_r;
      ih_s = ih_r;
    end
  end

  // Next counter values and the read-ahead address.
  always_comb begin
    accept_s   = bus.din_valid && !rst;
    col_last_s = is_last(col_r, iw_s);
    row_last_s = is_last(row_r, ih_s);
    if (col_last_s) begin
      col_nxt_s = '0;
      if (row_last_s) begin
        row_nxt_s = '0;
      end else begin
        row_nxt_s = row_r + 11'd1;
      end
    end else begin
      col_nxt_s = col_r + 11'd1;
      row_nxt_s = row_r;
    end
    // The RAMs have one cycle of read latency, so always address the column
    // the next accepted pixel will land on; its old words are then ready.
    if (rst) begin
      rd_addr_s = '0;
    end else if (bus.din_valid) begin
      rd_addr_s = col_nxt_s;
    end else begin
      rd_addr_s = col_r;
    end
    emit_s = accept_s && (row_r >= 11'd2) && (col_r >= 11'd2);
  end

  // Column/row counters and the per-frame geometry latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
      iw_r  <= '0;
      ih_r  <= '0;
    end else if (accept_s) begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
      if (frame_start_s) begin
        iw_r <= bus.IW;
        ih_r <= bus.IH;
      end
    end
  end

  window_line_ram #(
    .DW    (DW),
    .MAX_W (MAX_W),
    .AW    (AW)
  ) u_line0 (
    .clk   (clk),
    .we    (accept_s),
    .waddr (col_r[AW-1:0]),
    .wdata (bus.din),
    .raddr (rd_addr_s[AW-1:0]),
    .rdata (l0_rd_s)
  );

  window_line_ram #(
    .DW    (DW),
    .MAX_W (MAX_W),
    .AW    (AW)
  ) u_line1 (
    .clk   (clk),
    .we    (accept_s),
    .waddr (col_r[AW-1:0]),
    .wdata (l0_rd_s),
    .raddr (rd_addr_s[AW-1:0]),
    .rdata (l1_rd_s)
  );

  // Shift every array row left by one and append the new column on the right.
  always_comb begin
    win_nxt_s = win_r;
    for (int k = 0; k < KSZ; k++) begin
      for (int j = 0; j < KSZ - 1; j++) begin
        win_nxt_s[k*KSZ+j] = win_r[k*KSZ+j+1];
      end
    end
    win_nxt_s[E_TR] = l1_rd_s;
    win_nxt_s[E_MR] = l0_rd_s;
    win_nxt_s[E_BR] = bus.din;
  end

  // 3x3 array advances on every accepted pixel, including border pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_r <= '0;
    end else if (accept_s) begin
      win_r <= win_nxt_s;
    end
  end

  // Output window register: loads only when a full interior window exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_win_r   <= '0;
      out_mid_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= emit_s;
      if (emit_s) begin
        out_win_r <= win_nxt_s;
        out_mid_r <= win_nxt_s[WIN_MID];
      end
    end
  end

  assign bus.window_data_all = out_win_r;
  assign bus.window_mid      = out_mid_r;
  assign bus.dout_valid      = out_valid_r;

endmodule

// File: tb/tb_window_buffer_3x3.sv
// Self-checking bench: frames are held as 2D arrays and each expected window
// is read straight out of the frame at (r-2..r, c-2..c).
module tb_window_buffer_3x3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_buffer_3x3_if #(.DW(8))  bus8 ();
  window_buffer_3x3_if #(.DW(12)) bus12 ();

  window_buffer_3x3 #(.DW(8), .MAX_W(2048)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  window_buffer_3x3 #(.DW(12), .MAX_W(64)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12.slave)
  );

  int total = 0;
  int bad   = 0;
  int pix [0:15][0:15];
  int pulses;
  logic [71:0] last_win;
  logic [7:0]  last_mid;
  logic [71:0] first_win;
  logic [71:0] win_q [$];
  logic [71:0] t1_q  [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] model_win(int r, int c);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) begin
      w[8*i +: 8] = 8'(pix[r - 2 + i / 3][c - 2 + i % 3]);
    end
    return w;
  endfunction

  // Streams npix pixels of a w x h frame; mode 0 = row*16+col, 1 = random.
  task automatic send_frame(int w, int h, int gap_max, int npix, int mode);
    logic [71:0] ew;
    pulses = 0;
    win_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        pix[r][c] = (mode == 0) ? (r * 16 + c) : int'($urandom_range(0, 255));
      end
    end
    for (int n = 0; n < npix; n++) begin
      int r;
      int c;
      int gap;
      r = n / w;
      c = n % w;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gap; g++) begin
        bus8.din_valid = 1'b0;
        step();
        total++;
        if (bus8.dout_valid !== 1'b0 || bus8.window_data_all !== last_win) begin
          bad++;
          $display("FAIL gap_hold: dout_valid=%b win=%h expected 0 and %h", bus8.dout_valid,
                   bus8.window_data_all, last_win);
        end
      end
      if (n == 0) begin
        bus8.IW = 11'(w);
        bus8.IH = 11'(h);
      end
      bus8.din       = 8'(pix[r][c]);
      bus8.din_valid = 1'b1;
      step();
      bus8.din_valid = 1'b0;
      // geometry must be latched: scramble it for the rest of the frame
      bus8.IW = 11'($urandom_range(0, 2047));
      bus8.IH = 11'($urandom_range(0, 2047));
      total++;
      if (r >= 2 && c >= 2) begin
        ew = model_win(r, c);
        if (bus8.dout_valid !== 1'b1 || bus8.window_data_all !== ew || bus8.window_mid !== ew[39:32]) begin
          bad++;
          $display("FAIL window r=%0d c=%0d: valid=%b win=%h mid=%h expected 1 %h %h", r, c,
                   bus8.dout_valid, bus8.window_data_all, bus8.window_mid, ew, ew[39:32]);
        end
        if (pulses == 0) first_win = ew;
        pulses++;
        last_win = ew;
        last_mid = ew[39:32];
        win_q.push_back(bus8.window_data_all);
      end else begin
        if (bus8.dout_valid !== 1'b0 || bus8.window_data_all !== last_win || bus8.window_mid !== last_mid) begin
          bad++;
          $display("FAIL no_window r=%0d c=%0d: valid=%b win=%h expected 0 and held %h", r, c,
                   bus8.dout_valid, bus8.window_data_all, last_win);
        end
      end
    end
  endtask

  task automatic compare_to_t1(string name);
    total++;
    if (win_q.size() != t1_q.size()) begin
      bad++;
      $display("FAIL %s count: got %0d windows expected %0d", name, win_q.size(), t1_q.size());
    end else begin
      for (int i = 0; i < win_q.size(); i++) begin
        if (win_q[i] !== t1_q[i]) begin
          bad++;
          $display("FAIL %s win%0d: got %h expected %h", name, i, win_q[i], t1_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (bus8.dout_valid !== 1'b0 || bus8.window_data_all !== 72'h0 || bus8.window_mid !== 8'h0 ||
        bus12.dout_valid !== 1'b0 || bus12.window_data_all !== 108'h0 || bus12.window_mid !== 12'h0) begin
      bad++;
      $display("FAIL reset: valid=%b win=%h mid=%h expected all zero", bus8.dout_valid,
               bus8.window_data_all, bus8.window_mid);
    end
    rst = 1'b0;
    last_win = '0;
    last_mid = '0;
  endtask

  task automatic test_basic();
    send_frame(5, 4, 0, 20, 0);
    total++;
    if (pulses != 6) begin
      bad++;
      $display("FAIL t1_pulses: got %0d expected 6", pulses);
    end
    total++;
    if (first_win !== 72'h22_21_20_12_11_10_02_01_00 || win_q.size() == 0 ||
        win_q[0][39:32] !== 8'h11) begin
      bad++;
      $display("FAIL t1_first: got %h expected 222120121110020100", win_q.size() ? win_q[0] : 72'h0);
    end
    total++;
    if (last_mid !== 8'h23 || bus8.window_mid !== 8'h23) begin
      bad++;
      $display("FAIL t1_last_mid: got %h expected 23", bus8.window_mid);
    end
    t1_q = win_q;
  endtask

  task automatic test_gapped();
    send_frame(5, 4, 3, 20, 0);
    compare_to_t1("t2_gapped");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      send_frame(6, 5, 0, 30, 1);
      total++;
      if (pulses != 12) begin
        bad++;
        $display("FAIL t3_pulses frame%0d: got %0d expected 12", f, pulses);
      end
    end
  endtask

  task automatic test_mid_reset();
    send_frame(5, 4, 0, 13, 1);
    rst = 1'b1;
    bus8.din_valid = 1'b1;
    bus8.din = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 1) begin
        rst = 1'b0;
        bus8.din_valid = 1'b0;
      end
      total++;
      if (bus8.dout_valid !== 1'b0 || bus8.window_data_all !== 72'h0 || bus8.window_mid !== 8'h0) begin
        bad++;
        $display("FAIL t4_reset cyc%0d: valid=%b win=%h expected 0", i, bus8.dout_valid,
                 bus8.window_data_all);
      end
    end
    last_win = '0;
    last_mid = '0;
    send_frame(5, 4, 0, 20, 0);
    compare_to_t1("t4_after_reset");
  endtask

  task automatic test_degenerate();
    send_frame(2, 10, 0, 20, 1);
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL t5_narrow: got %0d pulses expected 0", pulses);
    end
    send_frame(5, 4, 0, 20, 0);
    compare_to_t1("t5_after_narrow");
    send_frame(10, 2, 1, 20, 1);
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL t5_short: got %0d pulses expected 0", pulses);
    end
    send_frame(5, 4, 0, 20, 0);
    compare_to_t1("t5_after_short");
  endtask

  task automatic test_dw12();
    int p12;
    p12 = 0;
    bus12.IW = 11'd3;
    bus12.IH = 11'd3;
    for (int n = 0; n < 10; n++) begin
      if (n < 9) begin
        bus12.din_valid = 1'b1;
        bus12.din = (n == 4) ? 12'h001 : 12'hFFF;
      end else begin
        bus12.din_valid = 1'b0;
      end
      step();
      bus12.din_valid = 1'b0;
      if (bus12.dout_valid === 1'b1) begin
        p12++;
        total++;
        if (n != 8 || bus12.window_mid !== 12'h001) begin
          bad++;
          $display("FAIL t6_mid: n=%0d mid=%h expected n=8 mid=001", n, bus12.window_mid);
        end
        for (int i = 0; i < 9; i++) begin
          logic [11:0] e;
          e = (i == 4) ? 12'h001 : 12'hFFF;
          total++;
          if (bus12.window_data_all[12*i +: 12] !== e) begin
            bad++;
            $display("FAIL t6_elem%0d: got %h expected %h", i, bus12.window_data_all[12*i +: 12], e);
          end
        end
      end
    end
    total++;
    if (p12 != 1) begin
      bad++;
      $display("FAIL t6_pulses: got %0d expected 1", p12);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.din_valid  = 1'b0;
    bus8.din        = '0;
    bus8.IW         = '0;
    bus8.IH         = '0;
    bus12.din_valid = 1'b0;
    bus12.din       = '0;
    bus12.IW        = '0;
    bus12.IH        = '0;
    last_win        = '0;
    last_mid        = '0;
    first_win       = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_mid_reset();
    test_degenerate();
    test_dw12();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
